// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC array control sequencer.
package mac_pkg;

  localparam int unsigned IDX_W          = 4;
  localparam int unsigned SHAMT_W        = 5;
  localparam int unsigned WAIT_CNT_W     = 6;
  localparam int unsigned WAIT_EXTRA_MAX = 15;

  typedef enum logic [2:0] {
    StIdle,
    StWload,
    StIload,
    StCalc,
    StWait,
    StOut
  } state_e;

  // Compute wait: systolic skew (2n+2) plus extra downstream pipeline cycles; max 47.
  function automatic logic [WAIT_CNT_W-1:0] wait_len(logic [IDX_W-1:0] n, int unsigned extra);
    return WAIT_CNT_W'({n, 1'b0}) + WAIT_CNT_W'(2) + WAIT_CNT_W'(extra);
  endfunction

endpackage

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for the MAC array control path: weight-row loads, input-column loads,
// compute start, fill/compute wait and output-row drain. All outputs are registered.
// Optional build macro MAC_SEQ_WREUSE_EN adds KEEP_W to skip WLOAD when weights are reusable.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned WAIT_EXTRA = 0
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               START,
  input  logic [IDX_W-1:0]   N_CFG,
  input  logic [SHAMT_W-1:0] SHAMT_CFG,
  input  logic               STALL,
`ifdef MAC_SEQ_WREUSE_EN
  input  logic               KEEP_W,
`endif
  output logic               BUSY,
  output logic               DONE,
  output logic               START_CALC,
  output logic               WLoad,
  output logic               ILoad,
  output logic               OWrite,
  output logic [SHAMT_W-1:0] shamt,
  output logic [IDX_W-1:0]   WROW,
  output logic [IDX_W-1:0]   ICOL,
  output logic [IDX_W-1:0]   ODST
);

  if (WAIT_EXTRA > WAIT_EXTRA_MAX) begin : gen_bad_wait_extra
    $error("WAIT_EXTRA out of range 0..15");
  end

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      n_q, n_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [SHAMT_W-1:0]    shamt_q, shamt_d;
  logic [IDX_W-1:0]      wrow_q, wrow_d, icol_q, icol_d, odst_q, odst_d;
  logic                  busy_q, busy_d, done_q, done_d, start_calc_q, start_calc_d;
  logic                  wload_q, wload_d, iload_q, iload_d, owrite_q, owrite_d;
  logic                  issued, last_idx, wait_last, skip_w;
`ifdef MAC_SEQ_WREUSE_EN
  logic                  reuse_vld_q, reuse_vld_d;
  logic [IDX_W-1:0]      last_n_q, last_n_d;
`endif

  // Next-state, shared phase counter and next registered outputs.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    cnt_d        = cnt_q;
    shamt_d      = shamt_q;
    wrow_d       = wrow_q;
    icol_d       = icol_q;
    odst_d       = odst_q;
    done_d       = 1'b0;
    skip_w       = 1'b0;
    // A stalled cycle issues nothing, so the index only advances after a real strobe.
    issued       = wload_q | iload_q | owrite_q;
    last_idx     = (cnt_q == WAIT_CNT_W'(n_q));
    wait_last    = (cnt_q == wait_len(n_q, WAIT_EXTRA) - WAIT_CNT_W'(1));
`ifdef MAC_SEQ_WREUSE_EN
    reuse_vld_d  = reuse_vld_q;
    last_n_d     = last_n_q;
    skip_w       = KEEP_W && reuse_vld_q && (N_CFG == last_n_q);
`endif

    unique case (state_q)
      StIdle: begin
        if (START) begin
          n_d     = N_CFG;
          shamt_d = SHAMT_CFG;
          cnt_d   = '0;
          wrow_d  = '0;
          icol_d  = '0;
          odst_d  = '0;
          state_d = skip_w ? StIload : StWload;
`ifdef MAC_SEQ_WREUSE_EN
          reuse_vld_d = 1'b0;
`endif
        end
      end
      StWload: begin
        if (issued) begin
          cnt_d = last_idx ? '0 : cnt_q + WAIT_CNT_W'(1);
          if (last_idx) state_d = StIload;
        end
      end
      StIload: begin
        if (issued) begin
          cnt_d = last_idx ? '0 : cnt_q + WAIT_CNT_W'(1);
          if (last_idx) state_d = StCalc;
        end
      end
      StCalc: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = wait_last ? '0 : cnt_q + WAIT_CNT_W'(1);
        if (wait_last) state_d = StOut;
      end
      StOut: begin
        if (issued) begin
          cnt_d = last_idx ? '0 : cnt_q + WAIT_CNT_W'(1);
          if (last_idx) begin
            state_d = StIdle;
            done_d  = 1'b1;
`ifdef MAC_SEQ_WREUSE_EN
            reuse_vld_d = 1'b1;
            last_n_d    = n_q;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Index outputs follow the counter only inside their own phase.
    case (state_d)
      StWload: wrow_d = cnt_d[IDX_W-1:0];
      StIload: icol_d = cnt_d[IDX_W-1:0];
      StOut:   odst_d = cnt_d[IDX_W-1:0];
      default: ;
    endcase

    wload_d      = (state_d == StWload) && !STALL;
    iload_d      = (state_d == StIload) && !STALL;
    owrite_d     = (state_d == StOut) && !STALL;
    start_calc_d = (state_d == StCalc);
    busy_d       = (state_d != StIdle);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q      <= StIdle;
      n_q          <= '0;
      cnt_q        <= '0;
      shamt_q      <= '0;
      wrow_q       <= '0;
      icol_q       <= '0;
      odst_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_calc_q <= 1'b0;
      wload_q      <= 1'b0;
      iload_q      <= 1'b0;
      owrite_q     <= 1'b0;
`ifdef MAC_SEQ_WREUSE_EN
      reuse_vld_q  <= 1'b0;
      last_n_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      shamt_q      <= shamt_d;
      wrow_q       <= wrow_d;
      icol_q       <= icol_d;
      odst_q       <= odst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      start_calc_q <= start_calc_d;
      wload_q      <= wload_d;
      iload_q      <= iload_d;
      owrite_q     <= owrite_d;
`ifdef MAC_SEQ_WREUSE_EN
      reuse_vld_q  <= reuse_vld_d;
      last_n_q     <= last_n_d;
`endif
    end
  end

  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign START_CALC = start_calc_q;
  assign WLoad      = wload_q;
  assign ILoad      = iload_q;
  assign OWrite     = owrite_q;
  assign shamt      = shamt_q;
  assign WROW       = wrow_q;
  assign ICOL       = icol_q;
  assign ODST       = odst_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: a phase-level job model produces the expected
// per-cycle output trace which is compared against the DUT. Honours MAC_SEQ_WREUSE_EN.
module tb_mac_seq_ctrl;

  localparam int unsigned WE = 0;

  logic       CLK, RSTN, START, STALL;
  logic [3:0] N_CFG;
  logic [4:0] SHAMT_CFG;
  logic       BUSY, DONE, START_CALC, WLoad, ILoad, OWrite;
  logic [4:0] shamt;
  logic [3:0] WROW, ICOL, ODST;
`ifdef MAC_SEQ_WREUSE_EN
  logic       KEEP_W;
  bit         keep_req = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Expected / observed vectors: {BUSY,DONE,START_CALC,WLoad,ILoad,OWrite,shamt,WROW,ICOL,ODST}
  logic [22:0] exp_q[$];
  logic [22:0] obs_q[$];
  bit          stl_q[$];
  int          stall_w[16], stall_i[16], stall_o[16];
  bit          m_vld = 1'b0;
  int          m_n = 0;

  mac_seq_ctrl #(.WAIT_EXTRA(WE)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .START     (START),
    .N_CFG     (N_CFG),
    .SHAMT_CFG (SHAMT_CFG),
    .STALL     (STALL),
`ifdef MAC_SEQ_WREUSE_EN
    .KEEP_W    (KEEP_W),
`endif
    .BUSY      (BUSY),
    .DONE      (DONE),
    .START_CALC(START_CALC),
    .WLoad     (WLoad),
    .ILoad     (ILoad),
    .OWrite    (OWrite),
    .shamt     (shamt),
    .WROW      (WROW),
    .ICOL      (ICOL),
    .ODST      (ODST)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [22:0] pack(input logic [5:0] f, input logic [4:0] sh,
                                       input int w, input int i, input int o);
    return {f, sh, 4'(w), 4'(i), 4'(o)};
  endfunction

  function automatic logic [22:0] observe();
    return {BUSY, DONE, START_CALC, WLoad, ILoad, OWrite, shamt, WROW, ICOL, ODST};
  endfunction

  task automatic clear_stalls();
    for (int k = 0; k < 16; k++) begin
      stall_w[k] = 0; stall_i[k] = 0; stall_o[k] = 0;
    end
  endtask

  task automatic rand_stalls(input int n);
    for (int k = 1; k <= n; k++) begin
      stall_w[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      stall_i[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      stall_o[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
    end
  endtask

  // Job model: phases laid out in order; stalls before item k show index k with no strobe.
  task automatic build_exp(input int n, input logic [4:0] sh, input bit skip_w);
    int w, i, o;
    w = 0; i = 0; o = 0;
    exp_q.delete(); stl_q.delete();
    if (!skip_w) begin
      for (int k = 0; k <= n; k++) begin
        w = k;
        repeat (stall_w[k]) begin exp_q.push_back(pack(6'b100000, sh, w, i, o)); stl_q.push_back(1); end
        exp_q.push_back(pack(6'b100100, sh, w, i, o)); stl_q.push_back(0);
      end
    end
    for (int k = 0; k <= n; k++) begin
      i = k;
      repeat (stall_i[k]) begin exp_q.push_back(pack(6'b100000, sh, w, i, o)); stl_q.push_back(1); end
      exp_q.push_back(pack(6'b100010, sh, w, i, o)); stl_q.push_back(0);
    end
    exp_q.push_back(pack(6'b101000, sh, w, i, o)); stl_q.push_back(0);
    repeat (2 * n + 2 + int'(WE)) begin exp_q.push_back(pack(6'b100000, sh, w, i, o)); stl_q.push_back(0); end
    for (int k = 0; k <= n; k++) begin
      o = k;
      repeat (stall_o[k]) begin exp_q.push_back(pack(6'b100000, sh, w, i, o)); stl_q.push_back(1); end
      exp_q.push_back(pack(6'b100001, sh, w, i, o)); stl_q.push_back(0);
    end
    exp_q.push_back(pack(6'b010000, sh, w, i, o)); stl_q.push_back(0);
  endtask

  // Drives one job from the current negedge and records the DUT trace (no checking here).
  task automatic play(input int n, input logic [4:0] sh, input int ign_t, input int abort_t);
    obs_q.delete();
    START = 1'b1; N_CFG = 4'(n); SHAMT_CFG = sh; STALL = 1'b0;
`ifdef MAC_SEQ_WREUSE_EN
    KEEP_W = keep_req;
`endif
    for (int t = 0; t < exp_q.size(); t++) begin
      @(negedge CLK);
      obs_q.push_back(observe());
      START = (t == ign_t);
      N_CFG = 4'($urandom); SHAMT_CFG = 5'($urandom);
`ifdef MAC_SEQ_WREUSE_EN
      KEEP_W = 1'($urandom);
`endif
      STALL = (t + 1 < exp_q.size()) ? stl_q[t+1] : 1'b0;
      if (t == abort_t) begin
        RSTN = 1'b0; START = 1'b1; STALL = 1'b0;
        @(negedge CLK); obs_q.push_back(observe());
        RSTN = 1'b1; START = 1'b0;
        @(negedge CLK); obs_q.push_back(observe());
        m_vld = 1'b0;
        return;
      end
    end
    m_vld = 1'b1; m_n = n;
  endtask

  task automatic test_reset();
    RSTN = 1'b0; START = 1'b1; STALL = 1'b0; N_CFG = 4'd5; SHAMT_CFG = 5'd9;
`ifdef MAC_SEQ_WREUSE_EN
    KEEP_W = 1'b0;
`endif
    repeat (2) @(negedge CLK);
    checks++;
    if (observe() !== 23'h0) begin
      errors++; $display("FAIL reset_state got %h expected %h", observe(), 23'h0);
    end
    RSTN = 1'b1; START = 1'b0;
    @(negedge CLK);
    checks++;
    if (observe() !== 23'h0) begin
      errors++; $display("FAIL reset_start_discard got %h expected %h", observe(), 23'h0);
    end
  endtask

  task automatic test_basic();
    int dc;
    clear_stalls();
    build_exp(3, 5'd7, 1'b0);
    play(3, 5'd7, -1, -1);
    dc = 0;
    for (int t = 0; t < exp_q.size(); t++) begin
      checks++;
      if (obs_q[t] !== exp_q[t]) begin
        errors++; $display("FAIL basic cyc %0d got %h expected %h", t + 1, obs_q[t], exp_q[t]);
      end
      if (obs_q[t][21] && dc == 0) dc = t + 1;
    end
    checks++;
    if (dc !== 22) begin errors++; $display("FAIL basic_done_cycle got %0d expected 22", dc); end
  endtask

  task automatic test_stall();
    int dc;
    clear_stalls();
    stall_w[1] = 2; stall_o[2] = 1;
    build_exp(3, 5'd7, 1'b0);
    play(3, 5'd7, -1, -1);
    dc = 0;
    for (int t = 0; t < exp_q.size(); t++) begin
      checks++;
      if (obs_q[t] !== exp_q[t]) begin
        errors++; $display("FAIL stall cyc %0d got %h expected %h", t + 1, obs_q[t], exp_q[t]);
      end
      if (obs_q[t][21] && dc == 0) dc = t + 1;
    end
    checks++;
    if (dc !== 25) begin errors++; $display("FAIL stall_done_cycle got %0d expected 25", dc); end
  endtask

  task automatic test_back_to_back();
    int dc;
    clear_stalls();
    build_exp(2, 5'd4, 1'b0);
    play(2, 5'd4, -1, -1);
    build_exp(0, 5'd31, 1'b0);
    play(0, 5'd31, -1, -1);
    dc = 0;
    for (int t = 0; t < exp_q.size(); t++) begin
      checks++;
      if (obs_q[t] !== exp_q[t]) begin
        errors++; $display("FAIL b2b cyc %0d got %h expected %h", t + 1, obs_q[t], exp_q[t]);
      end
      if (obs_q[t][21] && dc == 0) dc = t + 1;
    end
    checks++;
    if ({obs_q[0][19], obs_q[0][16:12]} !== 6'b111111) begin
      errors++; $display("FAIL b2b_first_wload got %b expected %b",
                         {obs_q[0][19], obs_q[0][16:12]}, 6'b111111);
    end
    checks++;
    if (dc !== 7) begin errors++; $display("FAIL b2b_done_gap got %0d expected 7", dc); end
  endtask

  task automatic test_reset_mid_wait();
    int dc;
    clear_stalls();
    build_exp(2, 5'd19, 1'b0);
    play(2, 5'd19, -1, 9);
    for (int t = 0; t <= 9; t++) begin
      checks++;
      if (obs_q[t] !== exp_q[t]) begin
        errors++; $display("FAIL abort_pre cyc %0d got %h expected %h", t + 1, obs_q[t], exp_q[t]);
      end
    end
    for (int t = 10; t < 12; t++) begin
      checks++;
      if (obs_q[t] !== 23'h0) begin
        errors++; $display("FAIL abort_clear cyc %0d got %h expected %h", t + 1, obs_q[t], 23'h0);
      end
    end
    build_exp(3, 5'd11, 1'b0);
    play(3, 5'd11, -1, -1);
    dc = 0;
    for (int t = 0; t < exp_q.size(); t++) begin
      checks++;
      if (obs_q[t] !== exp_q[t]) begin
        errors++; $display("FAIL after_abort cyc %0d got %h expected %h", t + 1, obs_q[t], exp_q[t]);
      end
      if (obs_q[t][21] && dc == 0) dc = t + 1;
    end
    checks++;
    if (dc !== 22) begin errors++; $display("FAIL after_abort_done got %0d expected 22", dc); end
  endtask

  task automatic test_ignored_start();
    int dc;
    clear_stalls();
    build_exp(3, 5'd2, 1'b0);
    play(3, 5'd2, 5, -1);
    dc = 0;
    for (int t = 0; t < exp_q.size(); t++) begin
      checks++;
      if (obs_q[t] !== exp_q[t]) begin
        errors++; $display("FAIL ign_start cyc %0d got %h expected %h", t + 1, obs_q[t], exp_q[t]);
      end
      if (obs_q[t][21] && dc == 0) dc = t + 1;
    end
    checks++;
    if (dc !== 22) begin errors++; $display("FAIL ign_start_done got %0d expected 22", dc); end
  endtask

  task automatic test_random();
    int n, gap;
    bit skip;
    logic [4:0] sh;
    logic [22:0] idle_v;
    for (int j = 0; j < 24; j++) begin
      n = int'($urandom_range(0, 15));
      sh = 5'($urandom);
      skip = 1'b0;
`ifdef MAC_SEQ_WREUSE_EN
      if ($urandom_range(0, 1) == 1) n = m_n;
      keep_req = 1'($urandom);
      skip = keep_req && m_vld && (n == m_n);
`endif
      clear_stalls();
      rand_stalls(n);
      build_exp(n, sh, skip);
      play(n, sh, -1, -1);
      for (int t = 0; t < exp_q.size(); t++) begin
        checks++;
        if (obs_q[t] !== exp_q[t]) begin
          errors++; $display("FAIL random job %0d n %0d cyc %0d got %h expected %h",
                             j, n, t + 1, obs_q[t], exp_q[t]);
        end
      end
      idle_v = {2'b00, exp_q[exp_q.size()-1][20:0]};
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        START = 1'b0; STALL = 1'($urandom);
        @(negedge CLK);
        checks++;
        if (observe() !== idle_v) begin
          errors++; $display("FAIL random_idle job %0d got %h expected %h", j, observe(), idle_v);
        end
      end
    end
`ifdef MAC_SEQ_WREUSE_EN
    keep_req = 1'b0;
`endif
  endtask

`ifdef MAC_SEQ_WREUSE_EN
  task automatic test_reuse();
    int dc;
    bit saw_wl;
    clear_stalls();
    keep_req = 1'b0;
    build_exp(2, 5'd3, 1'b0);
    play(2, 5'd3, -1, -1);
    keep_req = 1'b1;
    build_exp(2, 5'd6, 1'b1);
    play(2, 5'd6, -1, -1);
    dc = 0; saw_wl = 1'b0;
    for (int t = 0; t < exp_q.size(); t++) begin
      checks++;
      if (obs_q[t] !== exp_q[t]) begin
        errors++; $display("FAIL reuse cyc %0d got %h expected %h", t + 1, obs_q[t], exp_q[t]);
      end
      if (obs_q[t][21] && dc == 0) dc = t + 1;
      if (obs_q[t][19]) saw_wl = 1'b1;
    end
    checks++;
    if (dc !== 14 || saw_wl) begin
      errors++; $display("FAIL reuse_skip done %0d wload_seen %0d expected 14 0", dc, saw_wl);
    end
    build_exp(1, 5'd8, 1'b0);
    play(1, 5'd8, -1, -1);
    checks++;
    if (obs_q[0][19] !== 1'b1) begin
      errors++; $display("FAIL reuse_new_n wload got %b expected 1", obs_q[0][19]);
    end
    keep_req = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid_wait();
    test_ignored_start();
    test_random();
`ifdef MAC_SEQ_WREUSE_EN
    test_reuse();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for the MAC array control path. Accepts a job request (matrix size, output shift) and generates the per-cycle control stream consumed by the array's control pipeline register stage: weight-row loads, input-column loads, a calculation start pulse, a fill/compute wait, and output-row drain. Sits directly upstream of the control pipeline stage. Every output is registered so the downstream stage receives clean one-cycle-aligned controls.

## Interface
- WAIT_EXTRA, 0: extra wait cycles added after START_CALC; covers downstream pipeline stages. Legal range 0..15.
- CLK  in  1  clock; all logic on rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- START  in  1  job request; sampled only in IDLE.
- N_CFG  in  4  array extent minus one (n); rows/cols indexed 0..n.
- SHAMT_CFG  in  5  output shift amount for this job.
- STALL  in  1  memory not ready; freezes the load and drain phases.
- BUSY  out  1  high from the cycle after START acceptance until DONE.
- DONE  out  1  one-cycle pulse, job complete.
- START_CALC  out  1  one-cycle pulse entering compute.
- WLoad  out  1  weight-row write strobe.
- ILoad  out  1  input-column write strobe.
- OWrite  out  1  output-row read/write strobe.
- shamt  out  5  latched SHAMT_CFG, held for the whole job.
- WROW  out  4  weight row index.
- ICOL  out  4  input column index.
- ODST  out  4  output destination row.

## Operation
- States: IDLE, WLOAD, ILOAD, CALC, WAIT, OUT.
- IDLE: when START=1, latch n and shamt, then go to WLOAD. START is ignored in all other states. No queuing.
- WLOAD: WLoad=1, WROW steps 0..n, one step per non-stalled cycle. After WROW=n, go to ILOAD.
- ILOAD: ILoad=1, ICOL steps 0..n. After ICOL=n, go to CALC.
- CALC: START_CALC=1 for exactly one cycle. Next state is WAIT. STALL has no effect.
- WAIT: lasts 2n+2+WAIT_EXTRA cycles and covers systolic skew plus pipeline depth. STALL has no effect. Then go to OUT.
- OUT: OWrite=1, ODST steps 0..n. After ODST=n, go to IDLE with DONE=1 for one cycle.
- STALL=1 in WLOAD, ILOAD or OUT:
  - drop the strobe (WLoad/ILoad/OWrite) to 0;
  - hold the index;
  - do not advance.
  - When STALL falls, the held index is reissued with its strobe.
- Index outputs hold their last value outside their own phase. All indices clear to 0 on START acceptance.
- Wait counter is 6 bits wide; its maximum count is 47.

## Timing
- Reset: every output is 0 on the edge where RSTN=0 is sampled. State returns to IDLE. Reset mid-job aborts the job with no DONE. START sampled in the same cycle as RSTN=0 is discarded.
- START sampled at edge 0:
  - first WLOAD cycle is cycle 1;
  - with no stalls, DONE is high in cycle 5n+7+WAIT_EXTRA.
- Each stalled cycle in a load or drain phase adds exactly one cycle to the latency.
- START high in the DONE cycle is accepted, giving back-to-back jobs. WLoad is then high in the next cycle with the new shamt.
- n=0 is legal: each load and drain phase is a single cycle.

## Configuration
- MAC_SEQ_WREUSE_EN defined:
  - adds input KEEP_W (1 bit), sampled with START;
  - if KEEP_W=1, a prior job completed since reset, and N_CFG equals the previous n, WLOAD is skipped and ILOAD is entered directly, removing n+1 cycles;
  - otherwise behaviour is normal;
  - reset or an aborted job invalidates the reuse.
- Undefined: KEEP_W port is absent and WLOAD always runs.

## Structure
- Package mac_pkg holds:
  - state enum;
  - IDX_W=4, SHAMT_W=5, WAIT_CNT_W=6;
  - WAIT_EXTRA range limit.
- Single module with no sub-module. One shared phase counter serves the WLOAD/ILOAD/OUT indices and WAIT length.

## Test plan
- Basic job: n=3, SHAMT_CFG=7, WAIT_EXTRA=0, no stall.
  - WLoad cycles 1–4 (WROW 0..3), ILoad 5–8, START_CALC cycle 9, OWrite 18–21 (ODST 0..3), DONE cycle 22.
  - shamt=7 throughout; BUSY high cycles 1–21.
- Stall: n=3, STALL high for 2 cycles at WROW=1, 1 cycle at ODST=2.
  - WLoad low during stall, WROW holds 1.
  - DONE at cycle 25.
- Back-to-back: second START in the DONE cycle with n=0, SHAMT_CFG=31.
  - WLoad the next cycle with shamt=31.
  - Second DONE 7 cycles after the first.
- Reset mid-WAIT: RSTN low for one cycle.
  - All outputs 0, no DONE.
  - Next START runs a full job normally.
- Ignored START: START pulsed during ILOAD.
  - No effect on sequence or latency.
- MAC_SEQ_WREUSE_EN: two n=2 jobs, second with KEEP_W=1.
  - Second job has no WLoad and DONE after 14 cycles.
  - Third job with n=1, KEEP_W=1 performs WLOAD.
